timer_periph: RTL
=================

// Module: timer_periph
// PURPOSE
//   Memory-mapped timer/counter peripheral on the MEM-stage data bus, in parallel with DataMem.
//   Decodes 0x40000000-0x40000014 except 0x40000010 (7-seg, owned by DataMem).
//   Provides reload timer (TH/TL/TCON), LED output register, free-running systick.
//   Raises a level interrupt to the pipeline's exception logic.
// PARAMETERS
//   PRESCALE   1    clk cycles per TL increment (>=1); 1 = every enabled cycle
//   PS_BITS    8    prescaler counter width; must satisfy 2**PS_BITS >= PRESCALE
//   LED_BITS   8    width of LED register
// PORTS
//   clk         in   1         system clock, all state on posedge
//   reset       in   1         synchronous, active-high
//   Address     in   32        byte address from MEM stage
//   Write_data  in   32        store data
//   MemRead     in   1         load strobe
//   MemWrite    in   1         store strobe
//   Read_data   out  32        load data; 0 when no hit or MemRead=0 (OR-muxed with DataMem)
//   Hit         out  1         Address matches one of this block's registers
//   leds        out  LED_BITS  LED register contents
//   irq         out  1         TCON[1] & TCON[2]
// BEHAVIOUR
//   Map (full 32-bit compare; any other address incl. Address[1:0]!=0 -> no hit):
//     0x40000000 TH (rw, reload value)   0x40000004 TL (rw, counter)
//     0x40000008 TCON (rw, bits[2:0]; upper bits read 0)
//     0x4000000C LED (rw, [LED_BITS-1:0])   0x40000014 SYSTICK (ro, writes ignored)
//   TCON: [0] enable, [1] irq enable, [2] irq status (sticky).
//   Reset (reset=1 at posedge): TH=TL=0, TCON=0, LED=0, SYSTICK=0, prescaler=0; irq=0 next cycle.
//   Read: combinational, zero latency; Read_data = register when MemRead & Hit, else 0.
//   Write: takes effect at posedge with MemWrite & Hit; visible on reads next cycle.
//   SYSTICK: +1 every cycle unconditionally, wraps 0xFFFFFFFF -> 0.
//   Prescaler: counts 0..PRESCALE-1 while TCON[0]=1; tick when count==PRESCALE-1, then clears.
//     Held (not cleared) while TCON[0]=0. PRESCALE=1 -> tick every enabled cycle.
//   On tick: if TL==0xFFFFFFFF -> TL<=TH, and if TCON[1]=1 -> TCON[2]<=1; else TL<=TL+1.
//     Overflow while TCON[1]=0 reloads but does not set status.
//   TCON[2] cleared only by software write of 0 to bit 2 (or reset); writing 1 sets it.
//   Simultaneous events, same cycle:
//     - SW write TL vs tick: SW value wins, tick discarded.
//     - SW write TCON vs overflow: SW value wins for all 3 bits (overflow status lost).
//     - SW write TH vs overflow reload: reload uses OLD TH; new TH from next cycle.
//     - MemRead & MemWrite same address: Read_data returns old value.
//   Reset mid-count overrides all bus activity that cycle.
//   irq: registered-state derived, combinational from TCON; asserted cycle after status sets.
// STRUCTURE
//   Package timer_periph_pkg: address constants (TH/TL/TCON/LED/SYSTICK), TCON bit indices.
//   Sub-module tick_gen (prescaler: clk, reset, en -> tick); everything else in top.
// TESTING
//   1. Reset, read all 5 addrs -> all 0, irq=0, Hit=1 each; read 0x40000010 -> Hit=0, Read_data=0.
//   2. TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 (PRESCALE=1) -> TL: FFFFFFFF, FFFFFFFC, ...;
//      TCON reads 7 and irq=1 cycle after reload.
//   3. With irq=1, write TCON=3 -> irq=0 next cycle; counting continues from TL.
//   4. PRESCALE=4, TL=0, TCON=1 for 12 cycles -> TL=3; TCON=0 for 5 cycles -> TL unchanged.
//   5. Write TL=5 on same cycle as tick -> TL reads 5 (not 6); TH write on overflow -> old TH loaded.
//   6. Write LED=0xA5 -> leds=0xA5; write SYSTICK -> ignored, read advances by elapsed cycles;
//      reset asserted mid-count -> all regs 0 next cycle.

Source files
------------

// File: rtl/timer_periph_pkg.sv
// Register map, TCON bit positions and address decode shared by the
// timer peripheral and its prescaler.
package timer_periph_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SYSTICK
  } reg_sel_e;

  // 0x40000010 belongs to DataMem's 7-seg register, so it stays unmatched
  function automatic reg_sel_e decode(input logic [31:0] addr);
    case (addr)
      ADDR_TH:      decode = SEL_TH;
      ADDR_TL:      decode = SEL_TL;
      ADDR_TCON:    decode = SEL_TCON;
      ADDR_LED:     decode = SEL_LED;
      ADDR_SYSTICK: decode = SEL_SYSTICK;
      default:      decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_periph_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE enabled cycles; count is held
// while disabled so a pause resumes mid-period.
module tick_gen #(
  parameter int PRESCALE = 1,
  parameter int PS_BITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [PS_BITS-1:0] PS_MAX = PS_BITS'(PRESCALE - 1);

  logic [PS_BITS-1:0] cnt;

  assign tick = en && (cnt == PS_MAX);

  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped reload timer, LED register and free-running systick sitting
// beside DataMem on the MEM-stage bus; Read_data is zero when not selected.
module timer_periph
  import timer_periph_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PS_BITS  = 8,
  parameter int LED_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         Write_data,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [31:0]         Read_data,
  output logic                Hit,
  output logic [LED_BITS-1:0] leds,
  output logic                irq
);

  logic [31:0]         th, tl, systick;
  logic [2:0]          tcon;
  logic [LED_BITS-1:0] led_q;
  logic                tick, ovf;
  logic                wr_th, wr_tl, wr_tcon, wr_led;
  reg_sel_e            sel;

  assign sel     = decode(Address);
  assign Hit     = (sel != SEL_NONE);
  assign wr_th   = MemWrite && (sel == SEL_TH);
  assign wr_tl   = MemWrite && (sel == SEL_TL);
  assign wr_tcon = MemWrite && (sel == SEL_TCON);
  assign wr_led  = MemWrite && (sel == SEL_LED);

  tick_gen #(.PRESCALE(PRESCALE), .PS_BITS(PS_BITS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tcon[TCON_EN]),
    .tick  (tick)
  );

  assign ovf = tick && (tl == 32'hFFFF_FFFF);

  // Software writes take priority over same-cycle tick/overflow effects;
  // the reload reads th before any same-cycle TH write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led_q   <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_th) th <= Write_data;
      if (wr_tl)     tl <= Write_data;
      else if (tick) tl <= ovf ? th : tl + 32'd1;
      if (wr_tcon)                       tcon          <= Write_data[2:0];
      else if (ovf && tcon[TCON_IE])     tcon[TCON_IS] <= 1'b1;
      if (wr_led) led_q <= Write_data[LED_BITS-1:0];
    end
  end

  assign leds = led_q;
  assign irq  = tcon[TCON_IE] & tcon[TCON_IS];

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      case (sel)
        SEL_TH:      Read_data = th;
        SEL_TL:      Read_data = tl;
        SEL_TCON:    Read_data = {29'd0, tcon};
        SEL_LED:     Read_data = 32'(led_q);
        SEL_SYSTICK: Read_data = systick;
        default:     Read_data = '0;
      endcase
    end
  end

endmodule
